// File: rtl/rsa_xcel_naive_req_split.sv
// rsa_xcel_naive_req_split
// Splits a key-header + message word stream into one 96-bit {n, e, b}
// request per message word for the naive ModExp unit. A single output
// register decouples the two streams and refills in the cycle it drains.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RECV_N   | waiting for the modulus word n (reset state)
// RECV_E   | waiting for the exponent word e
// RECV_CNT | waiting for the message word count N
// DATA     | forwarding message words b, cnt_q holds words remaining
module rsa_xcel_naive_req_split (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] istream_msg,
  input  logic        istream_val,
  output logic        istream_rdy,
  output logic [95:0] ostream_msg,
  output logic        ostream_val,
  input  logic        ostream_rdy
);

  typedef enum logic [1:0] {
    RECV_N   = 2'd0,
    RECV_E   = 2'd1,
    RECV_CNT = 2'd2,
    DATA     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] n_q, n_d;
  logic [31:0] e_q, e_d;
  logic [31:0] cnt_q, cnt_d;
  logic [95:0] out_q, out_d;
  logic        out_val_q, out_val_d;

  logic        i_fire;
  logic        o_fire;

  // Header words never wait; data words wait only while the request
  // register is full and downstream is stalled.
  always_comb begin
    istream_rdy = 1'b1;
    if (state_q == DATA) begin
      istream_rdy = !out_val_q || ostream_rdy;
    end
  end

  assign i_fire      = istream_val && istream_rdy;
  assign o_fire      = out_val_q && ostream_rdy;
  assign ostream_msg = out_q;
  assign ostream_val = out_val_q;

  // Next-state logic: header decode, request capture and count tracking.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    e_d       = e_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    out_val_d = out_val_q;

    // A drain clears the register unless a new request lands this cycle.
    if (o_fire) begin
      out_val_d = 1'b0;
    end

    case (state_q)
      RECV_N: begin
        if (i_fire) begin
          n_d     = istream_msg;
          state_d = RECV_E;
        end
      end
      RECV_E: begin
        if (i_fire) begin
          e_d     = istream_msg;
          state_d = RECV_CNT;
        end
      end
      RECV_CNT: begin
        if (i_fire) begin
          cnt_d = istream_msg;
          // An empty message produces no requests.
          if (istream_msg == 32'd0) begin
            state_d = RECV_N;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (i_fire) begin
          // n and e are snapshotted so a following header cannot alter
          // a request that is still waiting on downstream.
          out_d     = {n_q, e_q, istream_msg};
          out_val_d = 1'b1;
          cnt_d     = cnt_q - 32'd1;
          if (cnt_q == 32'd1) begin
            state_d = RECV_N;
          end
        end
      end
      default: begin
        state_d = RECV_N;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RECV_N;
      n_q       <= 32'd0;
      e_q       <= 32'd0;
      cnt_q     <= 32'd0;
      out_q     <= 96'd0;
      out_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      e_q       <= e_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      out_val_q <= out_val_d;
    end
  end

endmodule

// File: tb/tb_rsa_xcel_naive_req_split.sv
// Self-checking bench for rsa_xcel_naive_req_split: a message-level model
// checked every cycle, plus literal request lists for the directed cases.
module tb_rsa_xcel_naive_req_split;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] istream_msg;
  logic        istream_val;
  logic        istream_rdy;
  logic [95:0] ostream_msg;
  logic        ostream_val;
  logic        ostream_rdy;

  int total = 0;
  int bad   = 0;

  // ostream_rdy control
  int   stall_cnt = 0;
  logic rand_rdy  = 1'b0;
  logic rdy_fixed = 1'b1;

  // behavioural model: phase 0=n,1=e,2=count,3=data
  int          phase = 0;
  logic [31:0] m_n   = 32'd0;
  logic [31:0] m_e   = 32'd0;
  logic [31:0] m_rem = 32'd0;
  logic        pv    = 1'b0;
  logic [95:0] pmsg  = 96'd0;

  logic [95:0] delivered[$];
  logic [95:0] exp_q[$];

  int tp_run  = 0;
  int tp_best = 0;
  int wsum    = 0;
  int w       = 0;

  always #5 clk = ~clk;

  rsa_xcel_naive_req_split dut (
    .clk         (clk),
    .reset       (reset),
    .istream_msg (istream_msg),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .ostream_msg (ostream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy)
  );

  function automatic void chk(string name, logic [95:0] act, logic [95:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  function automatic void fail_now(string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endfunction

  function automatic logic [95:0] req(logic [31:0] n, logic [31:0] e, logic [31:0] b);
    return {n, e, b};
  endfunction

  task automatic model_step();
    logic rdy_m, ifire, ofire;
    rdy_m = (phase != 3) || !pv || ostream_rdy;
    ifire = istream_val && rdy_m;
    ofire = pv && ostream_rdy;
    if (ofire) pv = 1'b0;
    if (ifire) begin
      case (phase)
        0: begin m_n = istream_msg; phase = 1; end
        1: begin m_e = istream_msg; phase = 2; end
        2: begin
          m_rem = istream_msg;
          phase = (istream_msg == 32'd0) ? 0 : 3;
        end
        default: begin
          pmsg  = {m_n, m_e, istream_msg};
          pv    = 1'b1;
          m_rem = m_rem - 32'd1;
          if (m_rem == 32'd0) phase = 0;
        end
      endcase
    end
  endtask

  // model update on every edge; reset clears it immediately
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      phase = 0; m_n = 0; m_e = 0; m_rem = 0; pv = 0; pmsg = 0;
    end else begin
      model_step();
    end
  end

  // per-cycle compare and delivery log, away from the active edge
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("istream_rdy", 96'(istream_rdy), 96'((phase != 3) || !pv || ostream_rdy));
      chk("ostream_val", 96'(ostream_val), 96'(pv));
      if (pv) chk("ostream_msg", ostream_msg, pmsg);
      if (ostream_val && ostream_rdy) delivered.push_back(ostream_msg);
    end
  end

  // downstream ready driver
  initial forever begin
    @(posedge clk);
    #2;
    if (stall_cnt > 0) begin
      ostream_rdy = 1'b0;
      stall_cnt--;
    end else if (rand_rdy) begin
      ostream_rdy = 1'($urandom_range(0, 1));
    end else begin
      ostream_rdy = rdy_fixed;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  // called only at posedge+1; returns at posedge+1 after the word is accepted
  task automatic send(input logic [31:0] wd, output int waited);
    istream_val = 1'b1;
    istream_msg = wd;
    waited = 0;
    @(negedge clk);
    while (!istream_rdy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) fail_now("send_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [31:0] n, input logic [31:0] e, input logic [31:0] c);
    int wt;
    send(n, wt);
    send(e, wt);
    send(c, wt);
  endtask

  task automatic drain(string name);
    int m;
    istream_val = 1'b0;
    rand_rdy    = 1'b0;
    rdy_fixed   = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk({name, "_count"}, 96'(delivered.size()), 96'(exp_q.size()));
    m = (delivered.size() < exp_q.size()) ? delivered.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk({name, "_req"}, delivered[i], exp_q[i]);
    delivered.delete();
    exp_q.delete();
  endtask

  initial begin
    reset       = 1'b1;
    istream_val = 1'b0;
    istream_msg = 32'd0;
    ostream_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_istream_rdy", 96'(istream_rdy), 96'd1);
    chk("reset_ostream_val", 96'(ostream_val), 96'd0);
    chk("reset_ostream_msg", ostream_msg, 96'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // basic message
    send_hdr(32'hBB, 32'h7, 32'h2);
    send(32'h58, w);
    exp_q.push_back(96'h000000BB_00000007_00000058);
    send(32'h41, w);
    exp_q.push_back(96'h000000BB_00000007_00000041);
    istream_val = 1'b0;
    @(negedge clk);
    chk("basic_latency_val", 96'(ostream_val), 96'd1);
    chk("basic_latency_msg", ostream_msg, 96'h000000BB_00000007_00000041);
    @(posedge clk);
    #1;
    drain("basic");

    // zero count followed immediately by a one-word message
    send_hdr(32'h11, 32'h3, 32'h0);
    send_hdr(32'h13, 32'h5, 32'h1);
    send(32'h2, w);
    exp_q.push_back(96'h00000013_00000005_00000002);
    drain("zero_cnt");

    // backpressure: 4 stalled cycles after the first data word
    send_hdr(32'h21, 32'h9, 32'h3);
    stall_cnt = 5;
    send(32'hA1, w);
    exp_q.push_back(req(32'h21, 32'h9, 32'hA1));
    fork
      begin
        send(32'hA2, w);
        exp_q.push_back(req(32'h21, 32'h9, 32'hA2));
      end
      begin
        repeat (4) begin
          @(negedge clk);
          chk("bp_istream_rdy", 96'(istream_rdy), 96'd0);
          chk("bp_msg_held", ostream_msg, 96'h00000021_00000009_000000A1);
        end
      end
    join
    send(32'hA3, w);
    exp_q.push_back(req(32'h21, 32'h9, 32'hA3));
    drain("backpressure");

    // header B absorbed while A's last request is still pending
    send_hdr(32'h31, 32'h4, 32'h1);
    stall_cnt = 8;
    send(32'hC1, w);
    exp_q.push_back(req(32'h31, 32'h4, 32'hC1));
    send(32'h41, w);
    chk("ovl_hdr_n_wait", 96'(w), 96'd0);
    send(32'h6, w);
    chk("ovl_hdr_e_wait", 96'(w), 96'd0);
    send(32'h2, w);
    chk("ovl_hdr_c_wait", 96'(w), 96'd0);
    istream_val = 1'b0;
    @(negedge clk);
    chk("ovl_pending_val", 96'(ostream_val), 96'd1);
    chk("ovl_pending_msg", ostream_msg, 96'h00000031_00000004_000000C1);
    @(posedge clk);
    #1;
    send(32'hD1, w);
    exp_q.push_back(req(32'h41, 32'h6, 32'hD1));
    send(32'hD2, w);
    exp_q.push_back(req(32'h41, 32'h6, 32'hD2));
    drain("overlap");

    // full throughput
    send_hdr(32'h61, 32'h3, 32'h8);
    wsum = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(32'h70 + 32'(i), w);
          wsum += w;
          exp_q.push_back(req(32'h61, 32'h3, 32'h70 + 32'(i)));
        end
        istream_val = 1'b0;
      end
      begin
        tp_run = 0;
        tp_best = 0;
        repeat (12) begin
          @(negedge clk);
          if (ostream_val) tp_run++;
          else tp_run = 0;
          if (tp_run > tp_best) tp_best = tp_run;
        end
      end
    join
    chk("tp_run", 96'(tp_best), 96'd8);
    chk("tp_waits", 96'(wsum), 96'd0);
    drain("throughput");

    // asynchronous reset between data words
    send_hdr(32'h5A, 32'h2, 32'h4);
    send(32'hB1, w);
    exp_q.push_back(req(32'h5A, 32'h2, 32'hB1));
    send(32'hB2, w);
    #2;
    istream_val = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_ostream_val", 96'(ostream_val), 96'd0);
    chk("arst_istream_rdy", 96'(istream_rdy), 96'd1);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    drain("pre_reset");
    send_hdr(32'h51, 32'h8, 32'h1);
    send(32'hE1, w);
    exp_q.push_back(96'h00000051_00000008_000000E1);
    drain("post_reset");

    // randomized messages with random downstream ready and input gaps
    rand_rdy = 1'b1;
    for (int m = 0; m < 40; m++) begin
      logic [31:0] rn, re, rb;
      int rc;
      rn = $urandom;
      re = $urandom;
      rc = $urandom_range(0, 5);
      send_hdr(rn, re, 32'(rc));
      for (int i = 0; i < rc; i++) begin
        rb = $urandom;
        send(rb, w);
        exp_q.push_back(req(rn, re, rb));
        if ($urandom_range(0, 3) == 0) begin
          istream_val = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        istream_val = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
